// File: rtl/div_if.sv
// Handshake/result bundle for div_unit; the requester holds the master modport, the divider the slave.
// Handshake: start is sampled only while the divider is idle (busy=0, done=0); done is a one-cycle pulse and results hold until the next completion.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, results for HI/LO with a done pulse.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operation via signed_op).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       clr,
    div_if.slave       bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q;   // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remd_q;
    logic             dz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic             last_step;
    logic             divisor_zero;
    logic             accept;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept       = (state_q == S_IDLE) && bus.start;
    assign divisor_zero = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic q_neg_q, r_neg_q;

    always_comb begin
        dvd_neg  = bus.signed_op & bus.dividend[WIDTH-1];
        dvs_neg  = bus.signed_op & bus.divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
        quot_fix = q_neg_q ? -dvd_q : dvd_q;
        rem_fix  = r_neg_q ? -rem_q : rem_q;
    end

    // Quotient sign follows the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
        end
    end
`else
    logic unused_signed_op;

    always_comb begin
        dvd_mag  = bus.dividend;
        dvs_mag  = bus.divisor;
        quot_fix = dvd_q;
        rem_fix  = rem_q;
    end

    assign unused_signed_op = bus.signed_op;
`endif

    // One extra bit lets the subtractor's MSB act as the borrow / sign of the trial result.
    assign shifted   = {rem_q, dvd_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign q_bit     = ~diff[WIDTH];
    assign last_step = (cnt_q == WIDTH'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = divisor_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            remd_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_q <= dvd_mag;
                        dvs_q <= dvs_mag;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (divisor_zero) begin
                            quot_q <= '1;
                            remd_q <= bus.dividend;
                            dz_q   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    rem_q <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                end
                S_FIX: begin
                    quot_q <= quot_fix;
                    remd_q <= rem_fix;
                    dz_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.div_by_zero = dz_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operands, busy-time start rejection and mid-CALC reset.
module tb_div_unit;
    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] state_dbg;

    div_if #(.WIDTH(W)) bus();

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer division; 64-bit math keeps most-negative / -1 well defined.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if (b == '0) begin
            exp_q.push_back('1);
            exp_q.push_back(a);
            exp_q.push_back(W'(1));
        end else if (sgn && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            exp_q.push_back(sq[W-1:0]);
            exp_q.push_back(sr[W-1:0]);
            exp_q.push_back('0);
        end else begin
            ua = longint'(a);
            ub = longint'(b);
            uq = ua / ub;
            ur = ua % ub;
            exp_q.push_back(uq[W-1:0]);
            exp_q.push_back(ur[W-1:0]);
            exp_q.push_back('0);
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                          input string tag, input bit poke);
        int cycles, busy_cnt, overlap, exp_lat;
        bit got;
        logic [W-1:0] eq, er, ez;
        model(a, b, sgn);
        exp_lat = (b == '0) ? 0 : W + 1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        // Operands need not stay stable after acceptance.
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.signed_op = 1'($urandom_range(0, 1));
        cycles = 0; busy_cnt = 0; overlap = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (poke && i == 4) begin
                    bus.start    = 1'b1;
                    bus.dividend = 9;
                    bus.divisor  = 3;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        bus.start = 1'b0;
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        ez = exp_q.pop_front();
        chk({tag, "_done_seen"}, W'(got), W'(1));
        chk({tag, "_latency"}, W'(cycles), W'(exp_lat));
        chk({tag, "_busy_until_done"}, W'(busy_cnt), W'(cycles));
        chk({tag, "_busy_done_overlap"}, W'(overlap), '0);
        chk({tag, "_quotient"}, bus.quotient, eq);
        chk({tag, "_remainder"}, bus.remainder, er);
        chk({tag, "_div_by_zero"}, W'(bus.div_by_zero), ez);
        @(posedge clk);
        #1;
        chk({tag, "_done_cleared"}, W'(bus.done), '0);
        chk({tag, "_quotient_held"}, bus.quotient, eq);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int sel, n_done;
        clr           = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_done", W'(bus.done), '0);
        chk("rst_quotient", bus.quotient, '0);
        chk("rst_remainder", bus.remainder, '0);
        chk("rst_dz", W'(bus.div_by_zero), '0);
        clr = 1'b1;

        run_op(32'd13, 32'd5, 1'b0, "u13_5", 1'b0);
        run_op(-32'sd13, 32'd5, 1'b1, "s_m13_5", 1'b0);
        run_op(-32'sd13, 32'd5, 1'b0, "u_m13_5", 1'b0);
        run_op(32'd13, 32'd0, 1'b0, "div0", 1'b0);
        run_op(32'd20, 32'd4, 1'b0, "after_div0", 1'b0);
        run_op(32'd13, 32'd0, 1'b1, "div0_signed", 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_overflow", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1", 1'b0);
        run_op(32'd100, 32'd7, 1'b0, "start_while_busy", 1'b1);

        // No second done may follow the ignored request.
        n_done = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        chk("ignored_start_no_done", W'(n_done), '0);

        // Abort mid-CALC: the operation must vanish without a done pulse.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd13;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", W'(bus.busy), '0);
        chk("abort_done", W'(bus.done), '0);
        chk("abort_quotient", bus.quotient, '0);
        chk("abort_remainder", bus.remainder, '0);
        chk("abort_dz", W'(bus.div_by_zero), '0);
        clr = 1'b1;
        n_done = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        chk("abort_no_done", W'(n_done), '0);
        run_op(32'd13, 32'd5, 1'b0, "after_abort", 1'b0);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            if (sel == 9) ra = 32'h8000_0000;
            case (sel)
                0:       rb = '0;
                1, 2, 3: rb = W'($urandom_range(1, 15));
                4:       rb = '1;
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
